flb_sar_ctrl: RTL and testbench
===============================

FLB_SAR_CTRL -- requirements
Module: flb_sar_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock for all logic; every register updates on its rising edge.
REQ-002 SHALL have port: csr_flb_rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: csr_flb_start  in  1  one-cycle pulse that starts a frequency-lock search.
REQ-004 SHALL have port: csr_flb_settle  in  4  number of DCO settle cycles inserted after each code change.
REQ-005 SHALL have port: cmp_vld  in  1  one-cycle strobe that marks a frequency comparison result.
REQ-006 SHALL have port: cmp_fast  in  1  comparison result, valid only with cmp_vld; 1 = DCO above target, so add capacitance.
REQ-007 SHALL have port: s_band  out  8  band code that drives the decoder s_band input.
REQ-008 SHALL have port: s_mtrx  out  8  matrix code that drives the decoder s_mtrx input.
REQ-009 SHALL have port: cmp_req  out  1  one-cycle pulse that requests one frequency comparison.
REQ-010 SHALL have port: busy  out  1  high while a search is running.
REQ-011 SHALL have port: done  out  1  level that rises when a search completes and clears on the next start.
REQ-012 SHALL have port: err  out  1  level that reports a comparator timeout and clears on the next start.

Function
REQ-013 SHALL implement these states: IDLE, SET, SETTLE, REQ, WAIT, DONE, ERR.
REQ-014 SHALL run two phases, each as an 8-step binary search (SAR), MSB first:
- Band phase: s_band is searched while s_mtrx is held at 8'h80.
- Matrix phase: s_mtrx is searched while s_band is held at the band result.
REQ-015 SHALL sample csr_flb_start only in IDLE, DONE or ERR, and ignore it in every other state.
REQ-016 SHALL, on an accepted start, perform all of the following in the next cycle:
- enter SET;
- load s_band=8'h80 and s_mtrx=8'h80;
- set the bit index to 7 and the phase to band;
- clear done and err;
- set busy.
REQ-017 SHALL leave SET for SETTLE and stay there exactly csr_flb_settle cycles, using a 4-bit down-counter; a value of 0 skips SETTLE.
REQ-018 SHALL assert cmp_req for exactly one cycle in REQ, then move to WAIT.
REQ-019 SHALL accept cmp_vld only in WAIT, and ignore cmp_vld in every other state.
REQ-020 SHALL, on cmp_vld in WAIT, keep the bit under test when cmp_fast=1 and clear it when cmp_fast=0; the updated code is visible the next cycle.
REQ-021 SHALL, when the index is above 0, also set the next lower bit in the same update, decrement the index and return to SET.
REQ-022 SHALL, at index 0 in the band phase, switch to the matrix phase, load s_mtrx=8'h80, set the index to 7 and return to SET.
REQ-023 SHALL, at index 0 in the matrix phase, enter DONE the next cycle with done=1 and busy=0, and hold both codes.
REQ-024 SHALL count WAIT cycles with an 8-bit counter; if 255 cycles pass without cmp_vld, it SHALL enter ERR with err=1 and busy=0, and hold both codes.
REQ-025 SHALL issue exactly 16 cmp_req pulses per successful search.
REQ-026 SHALL change s_band and s_mtrx only in the SET-entry updates and on accepted cmp_vld; each code is held stable through SETTLE, REQ and WAIT.
REQ-027 SHALL, in IDLE, DONE and ERR, keep the last codes and hold cmp_req=0.
REQ-028 SHALL give cmp_vld priority over a timeout expiring in the same cycle.

Reset
REQ-029 SHALL, when csr_flb_rst=1 at a clock edge, enter IDLE in the next cycle from any state, including mid-search.
REQ-030 SHALL hold these reset values: s_band=8'h00, s_mtrx=8'h00, cmp_req=0, busy=0, done=0, err=0, all counters=0, index=7, phase=band.
REQ-031 SHALL give reset priority over csr_flb_start and cmp_vld in the same cycle.

Verification
REQ-032 SHALL cover reset: hold csr_flb_rst=1 for 2 cycles -> all outputs at the REQ-030 values, and cmp_req stays 0 for 10 further idle cycles.
REQ-033 SHALL cover the nominal lock with settle=2 and cmp_vld returned 1 cycle after each cmp_req. Comparator model:
- band phase: cmp_fast=(s_band<=8'hD5);
- matrix phase: cmp_fast=(s_mtrx<=8'h3C).
Required result: done=1 with s_band=8'hD5 and s_mtrx=8'h3C; 16 cmp_req pulses seen; no cmp_req within 2 cycles after any code change.
REQ-034 SHALL cover the extremes: cmp_fast always 1 -> s_band=8'hFF, s_mtrx=8'hFF; cmp_fast always 0 -> s_band=8'h00, s_mtrx=8'h00; done=1 in both cases.
REQ-035 SHALL cover timeout: cmp_vld never returned -> err=1, busy=0 and s_band=8'h80 in the cycle after the 255th WAIT cycle; a later start clears err and restarts at 8'h80/8'h80.
REQ-036 SHALL cover reset mid-search: assert csr_flb_rst during the 5th WAIT -> IDLE next cycle with all REQ-030 values, and a start ignored in that same cycle.
REQ-037 SHALL cover start while busy: pulse csr_flb_start mid-search -> the search is unaffected, the final codes match REQ-033, and exactly 16 cmp_req pulses are seen.

Source files
------------

// File: rtl/flb_sar_ctrl.sv
// Frequency-lock SAR controller: two 8-step binary searches (band, then matrix)
// driven by a DCO-vs-target comparator, with settle delay and comparator timeout.
module flb_sar_ctrl (
  input  logic       clk,
  input  logic       csr_flb_rst,
  input  logic       csr_flb_start,
  input  logic [3:0] csr_flb_settle,
  input  logic       cmp_vld,
  input  logic       cmp_fast,
  output logic [7:0] s_band,
  output logic [7:0] s_mtrx,
  output logic       cmp_req,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, SET, SETTLE, REQ, WAIT, DONE, ERR} state_t;

  // Handshake: cmp_req is a one-cycle request issued in REQ; the comparator answers
  // later with a one-cycle cmp_vld strobe (cmp_fast valid with it), accepted only in WAIT.

  state_t     state, state_nxt;
  logic [7:0] band_nxt, mtrx_nxt;
  logic [2:0] bit_idx, bit_idx_nxt;
  logic       phase, phase_nxt;          // 0 = band, 1 = matrix
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [7:0] wait_cnt, wait_cnt_nxt;
  logic       busy_nxt, done_nxt, err_nxt;
  logic [7:0] code_upd;

  assign cmp_req = (state == REQ);

  always_ff @(posedge clk) begin
    if (csr_flb_rst) begin
      state      <= IDLE;
      s_band     <= 8'h00;
      s_mtrx     <= 8'h00;
      bit_idx    <= 3'd7;
      phase      <= 1'b0;
      settle_cnt <= 4'd0;
      wait_cnt   <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      s_band     <= band_nxt;
      s_mtrx     <= mtrx_nxt;
      bit_idx    <= bit_idx_nxt;
      phase      <= phase_nxt;
      settle_cnt <= settle_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    band_nxt       = s_band;
    mtrx_nxt       = s_mtrx;
    bit_idx_nxt    = bit_idx;
    phase_nxt      = phase;
    settle_cnt_nxt = settle_cnt;
    wait_cnt_nxt   = wait_cnt;
    busy_nxt       = busy;
    done_nxt       = done;
    err_nxt        = err;
    code_upd       = phase ? s_mtrx : s_band;

    case (state)
      IDLE, DONE, ERR: begin
        if (csr_flb_start) begin
          state_nxt   = SET;
          band_nxt    = 8'h80;
          mtrx_nxt    = 8'h80;
          bit_idx_nxt = 3'd7;
          phase_nxt   = 1'b0;
          done_nxt    = 1'b0;
          err_nxt     = 1'b0;
          busy_nxt    = 1'b1;
        end
      end
      SET: begin
        if (csr_flb_settle == 4'd0) begin
          state_nxt = REQ;
        end else begin
          state_nxt      = SETTLE;
          settle_cnt_nxt = csr_flb_settle;
        end
      end
      SETTLE: begin
        // Counter holds the remaining cycles including the current one.
        if (settle_cnt <= 4'd1) begin
          state_nxt      = REQ;
          settle_cnt_nxt = 4'd0;
        end else begin
          settle_cnt_nxt = settle_cnt - 4'd1;
        end
      end
      REQ: begin
        state_nxt    = WAIT;
        wait_cnt_nxt = 8'd0;
      end
      WAIT: begin
        if (cmp_vld) begin
          code_upd[bit_idx] = cmp_fast;
          if (bit_idx != 3'd0) begin
            code_upd[bit_idx - 3'd1] = 1'b1;
            bit_idx_nxt = bit_idx - 3'd1;
            state_nxt   = SET;
          end else if (!phase) begin
            phase_nxt   = 1'b1;
            mtrx_nxt    = 8'h80;
            bit_idx_nxt = 3'd7;
            state_nxt   = SET;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
          end
          if (phase) mtrx_nxt = code_upd;
          else       band_nxt = code_upd;
          wait_cnt_nxt = 8'd0;
        end else if (wait_cnt == 8'd254) begin
          // This is the 255th silent WAIT cycle.
          state_nxt    = ERR;
          err_nxt      = 1'b1;
          busy_nxt     = 1'b0;
          wait_cnt_nxt = 8'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_flb_sar_ctrl.sv
// Directed bench for flb_sar_ctrl: reset, nominal lock, extremes, timeout,
// mid-search reset and start-while-busy, with a reactive comparator model.
module tb_flb_sar_ctrl;

  logic       clk = 1'b0;
  logic       csr_flb_rst;
  logic       csr_flb_start;
  logic [3:0] csr_flb_settle;
  logic       cmp_vld;
  logic       cmp_fast;
  logic [7:0] s_band;
  logic [7:0] s_mtrx;
  logic       cmp_req;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;
  int req_count = 0;
  int chg_viol  = 0;
  int cyc       = 0;
  int last_chg  = -100;
  bit resp_en   = 1'b0;
  int resp_mode = 0;   // 0 nominal model, 1 always fast, 2 always slow
  bit pending;
  logic [7:0] prev_band = 8'h00;
  logic [7:0] prev_mtrx = 8'h00;

  flb_sar_ctrl dut (
    .clk            (clk),
    .csr_flb_rst    (csr_flb_rst),
    .csr_flb_start  (csr_flb_start),
    .csr_flb_settle (csr_flb_settle),
    .cmp_vld        (cmp_vld),
    .cmp_fast       (cmp_fast),
    .s_band         (s_band),
    .s_mtrx         (s_mtrx),
    .cmp_req        (cmp_req),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_search();
    req_count = 0;
    chg_viol  = 0;
    csr_flb_start = 1'b1;
    step();
    csr_flb_start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done || err) begin
        fin = 1'b1;
        break;
      end
      step();
    end
    check(tag, 32'(fin), 32'd1);
  endtask

  // request counter and settle-gap monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (s_band !== prev_band || s_mtrx !== prev_mtrx) last_chg = cyc;
    prev_band = s_band;
    prev_mtrx = s_mtrx;
    if (cmp_req === 1'b1) begin
      req_count++;
      if (cyc - last_chg <= 2) chg_viol++;
    end
  end

  // comparator: answers one cycle after each cmp_req
  initial begin
    cmp_vld  = 1'b0;
    cmp_fast = 1'b0;
    pending  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cmp_vld  = 1'b0;
      cmp_fast = 1'b0;
      if (pending) begin
        cmp_vld = 1'b1;
        case (resp_mode)
          1:       cmp_fast = 1'b1;
          2:       cmp_fast = 1'b0;
          default: cmp_fast = (req_count <= 8) ? (s_band <= 8'hD5) : (s_mtrx <= 8'h3C);
        endcase
      end
      pending = resp_en && (cmp_req === 1'b1);
    end
  end

  initial begin
    int n;
    csr_flb_rst    = 1'b1;
    csr_flb_start  = 1'b0;
    csr_flb_settle = 4'd2;

    // reset
    step();
    step();
    check("rst_band", 32'(s_band), 32'h00);
    check("rst_mtrx", 32'(s_mtrx), 32'h00);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err",  32'(err),  32'd0);
    check("rst_req",  32'(cmp_req), 32'd0);
    csr_flb_rst = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cmp_req !== 1'b0) n++;
    end
    check("idle_no_req", 32'(n), 32'd0);

    // nominal lock
    resp_en = 1'b1;
    resp_mode = 0;
    start_search();
    check("start_busy", 32'(busy), 32'd1);
    check("start_band", 32'(s_band), 32'h80);
    check("start_mtrx", 32'(s_mtrx), 32'h80);
    wait_end("nom_end");
    check("nom_done", 32'(done), 32'd1);
    check("nom_busy", 32'(busy), 32'd0);
    check("nom_band", 32'(s_band), 32'hD5);
    check("nom_mtrx", 32'(s_mtrx), 32'h3C);
    check("nom_reqs", 32'(req_count), 32'd16);
    check("nom_settle_gap", 32'(chg_viol), 32'd0);
    step();
    step();
    check("done_hold_band", 32'(s_band), 32'hD5);
    check("done_no_req", 32'(cmp_req), 32'd0);

    // extremes, with settle skipped on the all-fast run
    csr_flb_settle = 4'd0;
    resp_mode = 1;
    start_search();
    wait_end("fast_end");
    check("fast_done", 32'(done), 32'd1);
    check("fast_band", 32'(s_band), 32'hFF);
    check("fast_mtrx", 32'(s_mtrx), 32'hFF);
    check("fast_reqs", 32'(req_count), 32'd16);
    csr_flb_settle = 4'd2;
    resp_mode = 2;
    start_search();
    wait_end("slow_end");
    check("slow_done", 32'(done), 32'd1);
    check("slow_band", 32'(s_band), 32'h00);
    check("slow_mtrx", 32'(s_mtrx), 32'h00);

    // timeout: SET, 2x SETTLE, REQ, then 255 WAIT cycles
    resp_en = 1'b0;
    start_search();
    for (int i = 0; i < 258; i++) step();
    check("to_before_err", 32'(err), 32'd0);
    check("to_before_busy", 32'(busy), 32'd1);
    step();
    check("to_err",  32'(err),  32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check("to_band", 32'(s_band), 32'h80);
    check("to_done", 32'(done), 32'd0);
    resp_en = 1'b1;
    resp_mode = 0;
    start_search();
    check("restart_err",  32'(err), 32'd0);
    check("restart_band", 32'(s_band), 32'h80);
    check("restart_mtrx", 32'(s_mtrx), 32'h80);
    wait_end("restart_end");
    check("restart_result", 32'({s_band, s_mtrx}), 32'hD53C);

    // reset during the 5th WAIT, with start and cmp_vld in the same cycle
    start_search();
    n = 0;
    for (int i = 0; i < 500; i++) begin
      if (cmp_req === 1'b1) n++;
      if (n == 5) break;
      step();
    end
    check("mid_reached_req5", 32'(n), 32'd5);
    step();
    csr_flb_rst   = 1'b1;
    csr_flb_start = 1'b1;
    step();
    csr_flb_rst   = 1'b0;
    csr_flb_start = 1'b0;
    check("mid_band", 32'(s_band), 32'h00);
    check("mid_mtrx", 32'(s_mtrx), 32'h00);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_req",  32'(cmp_req), 32'd0);
    check("mid_flags", 32'({done, err}), 32'd0);
    step();
    step();
    check("mid_start_ignored", 32'({busy, cmp_req}), 32'd0);

    // start pulse while busy
    start_search();
    for (int i = 0; i < 20; i++) step();
    csr_flb_start = 1'b1;
    step();
    csr_flb_start = 1'b0;
    check("busy_mid", 32'(busy), 32'd1);
    wait_end("busy_end");
    check("busy_done", 32'(done), 32'd1);
    check("busy_band", 32'(s_band), 32'hD5);
    check("busy_mtrx", 32'(s_mtrx), 32'h3C);
    check("busy_reqs", 32'(req_count), 32'd16);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
